bfly_pipe: RTL and testbench

Pipelined, parametrised radix-2 butterfly with valid/ready flow control, a per-transaction DIT/DIF mode, optional 1-bit output scaling, round-half-up rotation and saturation.
- Next-generation FFT datapath element. It replaces the purely combinational butterfly between the twiddle source and the stage memories.
- One complex pair is accepted per cycle when the pipeline is not stalled.

---
 rtl/bfly_pkg.sv | 43 ++++
 rtl/cplx_rot_mul.sv | 55 +++++
 rtl/bfly_pipe.sv | 160 ++++++++++++++++
 tb/tb_bfly_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bfly_pkg.sv
// Shared types, component indices and fixed-point helpers for the radix-2 butterfly pipeline.
package bfly_pkg;

    localparam int RE     = 0;
    localparam int IM     = 1;
    localparam int WIDE_W = 64;

    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef struct packed {
        wide_t re;
        wide_t im;
    } cplx_wide_t;

    // Round half toward +inf, then drop frac fractional bits.
    function automatic wide_t round_shr(input wide_t v, input int frac);
        wide_t half;
        half = wide_t'(1) <<< (frac - 1);
        return (v + half) >>> frac;
    endfunction

    function automatic logic sat_ovf(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (w - 1));
        return (v > hi) || (v < lo);
    endfunction

    function automatic wide_t sat_clip(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/cplx_rot_mul.sv
// Registered complex rotation: full-precision multiply, round-half-up, saturate to IN_W or IN_W-1 bits.
module cplx_rot_mul
    import bfly_pkg::*;
#(
    parameter int IN_W      = 17,
    parameter int TW_W      = 16,
    parameter int FRAC_BITS = 15
) (
    input  logic                   clk_i,
    input  logic                   en_i,
    input  logic                   narrow_i,
    input  logic signed [IN_W-1:0] x_i  [2],
    input  logic signed [TW_W-1:0] tw_i [2],
    output logic signed [IN_W-1:0] y_o  [2],
    output logic                   sat_o
);

    localparam int PROD_W = IN_W + TW_W + 1;

    logic signed [PROD_W-1:0] xr, xi, tr, ti;
    logic signed [PROD_W-1:0] p_re, p_im;
    cplx_wide_t               rnd;
    int                       lim_w;
    logic signed [IN_W-1:0]   y_d [2];
    logic                     sat_d;
    logic signed [IN_W-1:0]   y_q [2];
    logic                     sat_q;

    always_comb begin
        xr    = PROD_W'(x_i[RE]);
        xi    = PROD_W'(x_i[IM]);
        tr    = PROD_W'(tw_i[RE]);
        ti    = PROD_W'(tw_i[IM]);
        p_re  = xr * tr - xi * ti;
        p_im  = xr * ti + xi * tr;
        rnd.re = round_shr(wide_t'(p_re), FRAC_BITS);
        rnd.im = round_shr(wide_t'(p_im), FRAC_BITS);
        // DIT operands are one bit narrower, so their rotation clips one bit earlier.
        lim_w  = narrow_i ? IN_W - 1 : IN_W;
        sat_d  = sat_ovf(rnd.re, lim_w) | sat_ovf(rnd.im, lim_w);
        y_d[RE] = IN_W'(sat_clip(rnd.re, lim_w));
        y_d[IM] = IN_W'(sat_clip(rnd.im, lim_w));
    end

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            y_q   <= y_d;
            sat_q <= sat_d;
        end
    end

    assign y_o   = y_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/bfly_pipe.sv
// Three-stage radix-2 butterfly (DIT/DIF per transaction) with valid/ready flow control.
module bfly_pipe
    import bfly_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 15,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic signed [DATA_WIDTH-1:0] twid_i [2],
    input  logic signed [DATA_WIDTH-1:0] a_i    [2],
    input  logic signed [DATA_WIDTH-1:0] b_i    [2],
    input  logic                         dif_i,
    input  logic                         scale_i,
    input  logic        [TAG_WIDTH-1:0]  tag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic signed [DATA_WIDTH:0]   a_o    [2],
    output logic signed [DATA_WIDTH:0]   b_o    [2],
    output logic        [TAG_WIDTH-1:0]  tag_o,
    output logic                         sat_o
);

    localparam int XW = DATA_WIDTH + 1;

    logic vld_p1_q, vld_p2_q, vld_p3_q;
    logic ld_p1, ld_p2, ld_p3;

    assign ld_p3      = !vld_p3_q || out_ready_i;
    assign ld_p2      = !vld_p2_q || ld_p3;
    assign ld_p1      = !vld_p1_q || ld_p2;
    assign in_ready_o = ld_p1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
        end else begin
            if (ld_p1) vld_p1_q <= in_valid_i;
            if (ld_p2) vld_p2_q <= vld_p1_q;
            if (ld_p3) vld_p3_q <= vld_p2_q;
        end
    end

    // ---- S1: DIF pre-add/subtract, DIT pass-through ----
    logic signed [XW-1:0]         u_d [2], x_d [2];
    logic signed [XW-1:0]         u_p1_q [2], x_p1_q [2];
    logic signed [DATA_WIDTH-1:0] tw_p1_q [2];
    logic                         dif_p1_q, scale_p1_q;
    logic        [TAG_WIDTH-1:0]  tag_p1_q;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            u_d[k] = dif_i ? XW'(a_i[k]) + XW'(b_i[k]) : XW'(a_i[k]);
            x_d[k] = dif_i ? XW'(a_i[k]) - XW'(b_i[k]) : XW'(b_i[k]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (ld_p1 && in_valid_i) begin
            u_p1_q     <= u_d;
            x_p1_q     <= x_d;
            tw_p1_q    <= twid_i;
            dif_p1_q   <= dif_i;
            scale_p1_q <= scale_i;
            tag_p1_q   <= tag_i;
        end
    end

    // ---- S2: rotation, plus sideband carried alongside ----
    logic                         en_p2;
    logic signed [XW-1:0]         wr_p2 [2];
    logic                         wsat_p2;
    logic signed [XW-1:0]         u_p2_q [2];
    logic                         dif_p2_q, scale_p2_q;
    logic        [TAG_WIDTH-1:0]  tag_p2_q;

    assign en_p2 = ld_p2 && vld_p1_q;

    cplx_rot_mul #(
        .IN_W      (XW),
        .TW_W      (DATA_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_rot (
        .clk_i    (clk_i),
        .en_i     (en_p2),
        .narrow_i (!dif_p1_q),
        .x_i      (x_p1_q),
        .tw_i     (tw_p1_q),
        .y_o      (wr_p2),
        .sat_o    (wsat_p2)
    );

    always_ff @(posedge clk_i) begin
        if (en_p2) begin
            u_p2_q     <= u_p1_q;
            dif_p2_q   <= dif_p1_q;
            scale_p2_q <= scale_p1_q;
            tag_p2_q   <= tag_p1_q;
        end
    end

    // ---- S3: DIT post-add/subtract, optional halving, output registers ----
    logic signed [XW-1:0] va, vb;
    wide_t                ra, rb;
    logic signed [XW-1:0] a_d [2], b_d [2];
    logic                 sat_d;
    logic signed [XW-1:0] a_q [2], b_q [2];
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 sat_q;

    always_comb begin
        va    = '0;
        vb    = '0;
        ra    = '0;
        rb    = '0;
        sat_d = wsat_p2;
        for (int k = 0; k < 2; k++) begin
            if (dif_p2_q) begin
                va = u_p2_q[k];
                vb = wr_p2[k];
            end else begin
                va = u_p2_q[k] + wr_p2[k];
                vb = u_p2_q[k] - wr_p2[k];
            end
            ra = scale_p2_q ? round_shr(wide_t'(va), 1) : wide_t'(va);
            rb = scale_p2_q ? round_shr(wide_t'(vb), 1) : wide_t'(vb);
            sat_d  = sat_d | sat_ovf(ra, XW) | sat_ovf(rb, XW);
            a_d[k] = XW'(sat_clip(ra, XW));
            b_d[k] = XW'(sat_clip(rb, XW));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < 2; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            tag_q <= '0;
            sat_q <= 1'b0;
        end else if (ld_p3 && vld_p2_q) begin
            a_q   <= a_d;
            b_q   <= b_d;
            tag_q <= tag_p2_q;
            sat_q <= sat_d;
        end
    end

    assign out_valid_o = vld_p3_q;
    assign a_o         = a_q;
    assign b_o         = b_q;
    assign tag_o       = tag_q;
    assign sat_o       = sat_q;

endmodule

// File: tb/tb_bfly_pipe.sv
// Scoreboard bench for bfly_pipe: directed vectors, backpressure, asynchronous reset mid-stream.
module tb_bfly_pipe;

    localparam int DW = 16;
    localparam int TW = 8;

    logic                 clk = 1'b0;
    logic                 rst_ni;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic signed [DW-1:0] twid_i [2];
    logic signed [DW-1:0] a_i    [2];
    logic signed [DW-1:0] b_i    [2];
    logic                 dif_i;
    logic                 scale_i;
    logic        [TW-1:0] tag_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic signed [DW:0]   a_o    [2];
    logic signed [DW:0]   b_o    [2];
    logic        [TW-1:0] tag_o;
    logic                 sat_o;

    always #5 clk = ~clk;

    bfly_pipe #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (15),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .twid_i      (twid_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .dif_i       (dif_i),
        .scale_i     (scale_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .a_o         (a_o),
        .b_o         (b_o),
        .tag_o       (tag_o),
        .sat_o       (sat_o)
    );

    typedef struct {
        int are;
        int aim;
        int bre;
        int bim;
        int tag;
        bit sat;
    } exp_t;

    exp_t sb[$];
    exp_t cur_exp;
    int   checks  = 0;
    int   errors  = 0;
    int   acc_cnt = 0;

    logic [4*(DW+1)+TW:0] out_bus, held_bus;
    logic                 hold_vld = 1'b0;
    assign out_bus = {a_o[0], a_o[1], b_o[0], b_o[1], tag_o, sat_o};

    // Acceptance pushes the expectation; output transfers pop and compare.
    always @(negedge clk) begin
        exp_t e;
        if (rst_ni && in_valid_i && in_ready_o) begin
            sb.push_back(cur_exp);
            acc_cnt++;
        end
        if (!rst_ni) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld && out_valid_o) begin
                checks++;
                if (out_bus !== held_bus) begin
                    errors++;
                    $display("FAIL stall_stable: output changed while stalled, got %h required %h", out_bus, held_bus);
                end
            end
            hold_vld = out_valid_o && !out_ready_i;
            held_bus = out_bus;
            if (out_valid_o && out_ready_i) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: tag=%0d appeared with nothing pending", tag_o);
                end else begin
                    e = sb.pop_front();
                    if (int'(a_o[0]) != e.are || int'(a_o[1]) != e.aim ||
                        int'(b_o[0]) != e.bre || int'(b_o[1]) != e.bim ||
                        int'(tag_o) != e.tag || sat_o !== e.sat) begin
                        errors++;
                        $display("FAIL result_tag%0d: got a=(%0d,%0d) b=(%0d,%0d) tag=%0d sat=%0b, required a=(%0d,%0d) b=(%0d,%0d) tag=%0d sat=%0b",
                                 e.tag, a_o[0], a_o[1], b_o[0], b_o[1], tag_o, sat_o,
                                 e.are, e.aim, e.bre, e.bim, e.tag, e.sat);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge, in_valid left high.
    task automatic send(input int twr, input int twi, input int ar, input int ai,
                        input int br, input int bi, input bit dif, input bit scl,
                        input int tag, input int ear, input int eai, input int ebr,
                        input int ebi, input bit esat);
        int n;
        twid_i[0]  = DW'(twr);
        twid_i[1]  = DW'(twi);
        a_i[0]     = DW'(ar);
        a_i[1]     = DW'(ai);
        b_i[0]     = DW'(br);
        b_i[1]     = DW'(bi);
        dif_i      = dif;
        scale_i    = scl;
        tag_i      = TW'(tag);
        cur_exp    = '{ear, eai, ebr, ebi, tag, esat};
        in_valid_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready_o && n < 60);
        if (!in_ready_o) begin
            chk("accept_timeout", 0, 1);
            in_valid_i = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen_low;
        int base;
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        dif_i       = 1'b0;
        scale_i     = 1'b0;
        tag_i       = '0;
        for (int k = 0; k < 2; k++) begin
            twid_i[k] = '0;
            a_i[k]    = '0;
            b_i[k]    = '0;
        end
        cur_exp = '{0, 0, 0, 0, 0, 1'b0};
        #12;
        chk("reset_out_valid", int'(out_valid_o), 0);
        chk("reset_outputs_zero", int'(out_bus), 0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        #1;
        chk("ready_after_reset", int'(in_ready_o), 1);
        @(posedge clk);
        #1;

        // Single DIT transaction with latency check.
        send(32767, 0, 1000, 200, 300, -400, 1'b0, 1'b0, 1, 1300, -200, 700, 600, 1'b0);
        in_valid_i = 1'b0;
        @(negedge clk); chk("latency_after_edge1", int'(out_valid_o), 0);
        @(negedge clk); chk("latency_after_edge2", int'(out_valid_o), 0);
        @(negedge clk); chk("latency_after_edge3", int'(out_valid_o), 1);
        @(posedge clk);
        #1;

        // Back-to-back directed vectors.
        send(0, -32768, 1000, 200, 300, -400, 1'b0, 1'b0, 2, 600, -100, 1400, 500, 1'b0);
        send(0, -32768, 1000, 200, 300, -400, 1'b0, 1'b1, 3, 300, -50, 700, 250, 1'b0);
        send(0, -32768, 1000, 200, 300, -400, 1'b1, 1'b0, 4, 1300, -200, 600, -700, 1'b0);
        send(-32768, 0, 0, 0, -32768, 0, 1'b0, 1'b0, 5, 32767, 0, -32767, 0, 1'b1);
        in_valid_i = 1'b0;
        drain("drain_directed");

        // Backpressure: tags 1..10 streamed with output stalled for 6 cycles.
        out_ready_i = 1'b0;
        base = acc_cnt;
        seen_low = 1'b0;
        fork
            begin
                for (int t = 1; t <= 10; t++)
                    send(32767, 0, t, 2 * t, t, -t, 1'b0, 1'b0, t, 2 * t, t, 0, 3 * t, 1'b0);
                in_valid_i = 1'b0;
            end
            begin
                repeat (6) begin
                    @(negedge clk);
                    if (!in_ready_o && !seen_low) begin
                        seen_low = 1'b1;
                        chk("accepts_before_full", acc_cnt - base, 3);
                    end
                end
                if (!seen_low)
                    chk("in_ready_fell", 0, 1);
                @(posedge clk);
                #1;
                out_ready_i = 1'b1;
                #1;
                chk("full_pop_push_ready", int'(in_ready_o), 1);
                chk("full_pop_push_valid", int'(out_valid_o), 1);
            end
        join
        drain("drain_stream");

        // Reset with three transactions in flight.
        send(32767, 0, 7, 7, 7, 7, 1'b0, 1'b0, 21, 14, 14, 0, 0, 1'b0);
        send(32767, 0, 8, 8, 8, 8, 1'b0, 1'b0, 22, 16, 16, 0, 0, 1'b0);
        send(32767, 0, 9, 9, 9, 9, 1'b0, 1'b0, 23, 18, 18, 0, 0, 1'b0);
        in_valid_i = 1'b0;
        #1;
        rst_ni = 1'b0;
        sb.delete();
        #1;
        chk("midreset_out_valid", int'(out_valid_o), 0);
        chk("midreset_outputs_zero", int'(out_bus), 0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        #1;
        chk("ready_after_midreset", int'(in_ready_o), 1);
        repeat (8) @(negedge clk);
        chk("no_stale_valid", int'(out_valid_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
